sram_port_ctrl: RTL

Initiator-side controller for a single-port 1RW OpenRAM macro port. Requests arrive on a valid/ready interface and are driven onto the macro's csb0/web0/addr0/din0 pins. Read data is captured from dout0 and returned in order on a valid/ready response interface. Sits between the SoC/BIST request logic and the generated SRAM macro; one request per cycle, back-pressure via response credits.

---
 rtl/sram_port_pkg.sv | 14 +
 rtl/sram_port_rsp_fifo.sv | 54 +++++
 rtl/sram_port_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/sram_port_pkg.sv
// Shared constants and request bundle for the OpenRAM 1RW port controller.
package sram_port_pkg;

    localparam int SRAM_DATA_WIDTH = 2;
    localparam int SRAM_ADDR_WIDTH = 4;
    localparam int READ_LAT        = 2;

    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_port_rsp_fifo.sv
// In-order read-response buffer between the macro capture point and the consumer.
module sram_port_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop & (count != '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= nxt(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Credit gating upstream makes this unreachable.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && count == CW'(DEPTH))
    );

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a single 1RW OpenRAM macro port with
// credit-based back-pressure and in-order read responses.
module sram_port_ctrl
    import sram_port_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int UW = CW + 1;
    localparam int IW = $clog2(READ_LAT + 1);

    logic                accept;
    logic [READ_LAT-1:0] rd_pipe;
    logic [IW-1:0]       inflight;
    logic [CW-1:0]       fifo_count;
    logic [UW-1:0]       used;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + IW'(rd_pipe[i]);
        end
    end

    // Every outstanding read owns a FIFO slot from accept until it is popped.
    assign used      = UW'(fifo_count) + UW'(inflight);
    assign req_ready = rstb0 & (used < UW'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (fifo_count != '0);

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            rd_pipe    <= '0;
        end else begin
            rd_pipe <= {rd_pipe[READ_LAT-2:0], accept & ~req_we};
            if (accept) begin
                sram_csb0  <= 1'b0;
                sram_web0  <= ~req_we;
                sram_addr0 <= req_addr;
                if (req_we) begin
                    sram_din0 <= req_wdata;
                end
            end else begin
                sram_csb0 <= 1'b1;
                sram_web0 <= 1'b1;
            end
        end
    end

    sram_port_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk0),
        .rst_n (rstb0),
        .push  (rd_pipe[READ_LAT-1]),
        .wdata (sram_dout0),
        .pop   (rsp_ready),
        .rdata (rsp_rdata),
        .count (fifo_count)
    );

endmodule
